router_mode_scheduler: RTL and testbench

- Sequences one mesh router through a programmed list of routing phases.
- Each phase is a router_mode value plus a beat count; the block drives router_mode for the current phase.
- It also round-robin arbitrates the four input ports (N, S, W, E) so that at most one input enable reaches the router per cycle.
- Sits beside each router in the cluster NoC; programmed by the top-level config bus before each layer.

---
 rtl/router_mode_scheduler.sv | 157 +++++++++++++++
 tb/tb_router_mode_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_mode_scheduler.sv
// Steps one mesh router through a programmed table of {router_mode, beats} phases
// and round-robin arbitrates the N/S/W/E input enables while a phase is running.
module router_mode_scheduler #(
  parameter  int NUM_ENTRIES = 8,
  parameter  int CNT_WIDTH   = 8,
  localparam int IDX_WIDTH   = $clog2(NUM_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [IDX_WIDTH-1:0] cfg_addr,
  input  logic [3:0]           cfg_mode,
  input  logic [CNT_WIDTH-1:0] cfg_beats,
  input  logic [IDX_WIDTH:0]   cfg_num,
  input  logic                 start,
  input  logic [3:0]           req_i,
  output logic [3:0]           grant_o,
  output logic [3:0]           router_mode_o,
  output logic                 beat_o,
  output logic [IDX_WIDTH-1:0] phase_o,
  output logic                 busy_o,
  output logic                 done_o
);

  // state | meaning
  // IDLE  | waiting for start; table writable
  // LOAD  | fetch entry idx; skip it when beats=0
  // RUN   | arbitrate ports, count beats of the current phase
  // DONE  | one-cycle completion pulse, router back to disabled
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [3:0]           MODE_OFF = 4'hF;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);
  localparam logic [IDX_WIDTH:0]   NUM_ONE  = (IDX_WIDTH + 1)'(1);

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH:0]   num_q, num_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [3:0]           mode_q, mode_d;
  logic [3:0]           tbl_mode_q  [NUM_ENTRIES];
  logic [3:0]           tbl_mode_d  [NUM_ENTRIES];
  logic [CNT_WIDTH-1:0] tbl_beats_q [NUM_ENTRIES];
  logic [CNT_WIDTH-1:0] tbl_beats_d [NUM_ENTRIES];

  logic [3:0] arb_grant;
  logic [1:0] arb_port;
  logic       arb_found;
  logic       is_last;
  logic       beat;

  // Port index 0..3 = N,S,W,E maps to req bit 3..0; search starts at the pointer.
  always_comb begin
    arb_grant = 4'b0000;
    arb_port  = ptr_q;
    arb_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] p;
      p = ptr_q + 2'(i);
      if (!arb_found && req_i[2'd3 - p]) begin
        arb_found            = 1'b1;
        arb_port             = p;
        arb_grant[2'd3 - p]  = 1'b1;
      end
    end
  end

  assign is_last = ({1'b0, idx_q} == (num_q - NUM_ONE));
  assign beat    = (state_q == S_RUN) && arb_found;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    mode_d      = mode_q;
    tbl_mode_d  = tbl_mode_q;
    tbl_beats_d = tbl_beats_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          tbl_mode_d[cfg_addr]  = cfg_mode;
          tbl_beats_d[cfg_addr] = cfg_beats;
        end
        if (start) begin
          idx_d   = '0;
          num_d   = cfg_num;
          state_d = (cfg_num == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (tbl_beats_q[idx_q] == '0) begin
          if (is_last) state_d = S_DONE;
          else         idx_d   = idx_q + IDX_ONE;
        end else begin
          mode_d  = tbl_mode_q[idx_q];
          cnt_d   = tbl_beats_q[idx_q];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (beat) begin
          cnt_d = cnt_q - CNT_ONE;
          ptr_d = arb_port + 2'd1;
          if (cnt_q == CNT_ONE) begin
            if (is_last) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IDX_ONE;
              state_d = S_LOAD;
            end
          end
        end
      end
      S_DONE: begin
        mode_d  = MODE_OFF;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= 2'd0;
      mode_q  <= MODE_OFF;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_mode_q[i]  <= MODE_OFF;
        tbl_beats_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      mode_q      <= mode_d;
      tbl_mode_q  <= tbl_mode_d;
      tbl_beats_q <= tbl_beats_d;
    end
  end

  assign grant_o       = (state_q == S_RUN) ? arb_grant : 4'b0000;
  assign beat_o        = beat;
  assign router_mode_o = mode_q;
  assign phase_o       = idx_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);

endmodule

// File: tb/tb_router_mode_scheduler.sv
// Scoreboard bench for router_mode_scheduler: expected beats are queued before each
// sequence and matched against every observed beat_o.
module tb_router_mode_scheduler;

  localparam int IDX_WIDTH = 3;
  localparam int CNT_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_we = 1'b0;
  logic [IDX_WIDTH-1:0] cfg_addr = '0;
  logic [3:0]           cfg_mode = '0;
  logic [CNT_WIDTH-1:0] cfg_beats = '0;
  logic [IDX_WIDTH:0]   cfg_num = '0;
  logic                 start = 1'b0;
  logic [3:0]           req_i = '0;
  logic [3:0]           grant_o;
  logic [3:0]           router_mode_o;
  logic                 beat_o;
  logic [IDX_WIDTH-1:0] phase_o;
  logic                 busy_o;
  logic                 done_o;

  router_mode_scheduler #(.NUM_ENTRIES(8), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mode(cfg_mode), .cfg_beats(cfg_beats), .cfg_num(cfg_num),
    .start(start), .req_i(req_i), .grant_o(grant_o),
    .router_mode_o(router_mode_o), .beat_o(beat_o), .phase_o(phase_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] mode;
    logic [2:0] phase;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   beats_seen = 0;
  int   done_cnt = 0;
  bit   saw_phase1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (phase_o == 3'd1 && busy_o) saw_phase1 = 1'b1;
      if (done_o) done_cnt++;
      if (beat_o) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {28'b0, grant_o}, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("grant", {28'b0, grant_o}, {28'b0, e.grant});
          chk("mode",  {28'b0, router_mode_o}, {28'b0, e.mode});
          chk("phase", {29'b0, phase_o}, {29'b0, e.phase});
        end
      end
    end
  end

  task automatic push(input logic [3:0] g, input logic [3:0] m, input logic [2:0] p);
    exp_t e;
    e.grant = g; e.mode = m; e.phase = p;
    exp_q.push_back(e);
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [3:0] m, input logic [7:0] b);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_mode = m; cfg_beats = b;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] num);
    @(posedge clk); #1;
    cfg_num = num; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 300 && done_cnt < target; i++) begin
      @(negedge clk); #1;
    end
    chk("done_seen", done_cnt, target);
  endtask

  task automatic wait_beats(input int target);
    for (int i = 0; i < 300 && beats_seen < target; i++) @(posedge clk);
    #1;
    chk("beats_reached", beats_seen, target);
  endtask

  task automatic run_one(input logic [3:0] num);
    int d;
    d = done_cnt;
    pulse_start(num);
    wait_done(d + 1);
    @(negedge clk);
    chk("mode_off_after_done", {28'b0, router_mode_o}, 32'hF);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int b0, d0;
    #12;
    @(negedge clk);
    chk("rst_mode", {28'b0, router_mode_o}, 32'hF);
    chk("rst_grant", {28'b0, grant_o}, 32'h0);
    chk("rst_busy_done_beat", {29'b0, busy_o, done_o, beat_o}, 32'h0);
    chk("rst_phase", {29'b0, phase_o}, 32'h0);
    rst_n = 1'b1;

    // round robin, all ports requesting, pointer starts at N
    write_entry(3'd0, 4'd2, 8'd4);
    req_i = 4'b1111;
    push(4'b1000, 4'd2, 3'd0); push(4'b0100, 4'd2, 3'd0);
    push(4'b0010, 4'd2, 3'd0); push(4'b0001, 4'd2, 3'd0);
    run_one(4'd1);

    // only N and E requesting
    write_entry(3'd0, 4'd4, 8'd4);
    req_i = 4'b1001;
    push(4'b1000, 4'd4, 3'd0); push(4'b0001, 4'd4, 3'd0);
    push(4'b1000, 4'd4, 3'd0); push(4'b0001, 4'd4, 3'd0);
    run_one(4'd1);

    // single phase, W only; pointer ends at E
    write_entry(3'd0, 4'd1, 8'd3);
    req_i = 4'b0010;
    push(4'b0010, 4'd1, 3'd0); push(4'b0010, 4'd1, 3'd0); push(4'b0010, 4'd1, 3'd0);
    run_one(4'd1);

    // multi-phase with a skipped entry
    write_entry(3'd0, 4'd5, 8'd2);
    write_entry(3'd1, 4'd3, 8'd0);
    write_entry(3'd2, 4'd9, 8'd1);
    req_i = 4'b1111;
    saw_phase1 = 1'b0;
    push(4'b0001, 4'd5, 3'd0); push(4'b1000, 4'd5, 3'd0); push(4'b0100, 4'd9, 3'd2);
    run_one(4'd3);
    chk("phase1_visited", {31'b0, saw_phase1}, 32'h1);

    // stall mid-phase, with ignored start and cfg_we while busy
    write_entry(3'd0, 4'd7, 8'd4);
    push(4'b0010, 4'd7, 3'd0); push(4'b0001, 4'd7, 3'd0);
    push(4'b1000, 4'd7, 3'd0); push(4'b0100, 4'd7, 3'd0);
    d0 = done_cnt;
    b0 = beats_seen;
    pulse_start(4'd1);
    wait_beats(b0 + 2);
    req_i = 4'b0000;
    start = 1'b1; cfg_num = 4'd3;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_mode = 4'd3; cfg_beats = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("stall_no_beat", beats_seen, b0 + 2);
    chk("stall_busy", {31'b0, busy_o}, 32'h1);
    req_i = 4'b1111;
    wait_done(d0 + 1);
    chk("stall_sb_drained", exp_q.size(), 0);

    // entry 0 must still hold {7,4}
    push(4'b0010, 4'd7, 3'd0); push(4'b0001, 4'd7, 3'd0);
    push(4'b1000, 4'd7, 3'd0); push(4'b0100, 4'd7, 3'd0);
    run_one(4'd1);

    // start with cfg_num=0 goes straight to DONE
    d0 = done_cnt;
    b0 = beats_seen;
    @(posedge clk); #1;
    cfg_num = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("num0_done", {30'b0, done_o, busy_o}, 32'h3);
    @(negedge clk);
    chk("num0_done_one_cycle", {30'b0, done_o, busy_o}, 32'h0);
    chk("num0_no_beats", beats_seen, b0);

    // async reset mid-RUN
    write_entry(3'd0, 4'd6, 8'd5);
    push(4'b0010, 4'd6, 3'd0);
    b0 = beats_seen;
    pulse_start(4'd1);
    wait_beats(b0 + 1);
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mode", {28'b0, router_mode_o}, 32'hF);
    chk("arst_grant", {28'b0, grant_o}, 32'h0);
    chk("arst_busy_done", {30'b0, busy_o, done_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("arst_no_done", done_cnt, d0);

    // table reset to beats=0: entry 0 skipped, no grants
    b0 = beats_seen;
    run_one(4'd1);
    chk("tbl_reset_no_beats", beats_seen, b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
